// File: rtl/sprite_blitter_if.sv
// ---------------------------------------------------------------------------
// sprite_blitter_if
//   Bundles the sprite blitter's request handshake, sprite-ROM port and
//   VGA pixel-write port into one interface.
//
//   Signals:
//     start, x_pos_init, y_pos_init, erase, hflip, bg_colour : draw request
//     rom_addr (to ROM), rom_q (from ROM, one cycle after rom_addr)
//     x, y, colour, plot : pixel-write port towards the VGA adapter
//     busy, done         : draw status back to the requester
//
//   Modports:
//     slave  : the blitter itself
//     master : its environment (requester, sprite ROM and VGA adapter).
//              The ROM data therefore comes from the master side.
// ---------------------------------------------------------------------------
interface sprite_blitter_if #(
    parameter int ADDR_W   = 10,
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int COLOUR_W = 3
);
    logic                start;
    logic [X_W-1:0]      x_pos_init;
    logic [Y_W-1:0]      y_pos_init;
    logic                erase;
    logic                hflip;
    logic [COLOUR_W-1:0] bg_colour;

    logic [ADDR_W-1:0]   rom_addr;
    logic [COLOUR_W-1:0] rom_q;

    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
    logic                busy;
    logic                done;

    modport slave (
        input  start, x_pos_init, y_pos_init, erase, hflip, bg_colour, rom_q,
        output rom_addr, x, y, colour, plot, busy, done
    );

    modport master (
        output start, x_pos_init, y_pos_init, erase, hflip, bg_colour, rom_q,
        input  rom_addr, x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/sprite_blitter.sv
// ---------------------------------------------------------------------------
// sprite_blitter
//   Streams a SPRITE_W x SPRITE_H bitmap from a synchronous sprite ROM to
//   the VGA pixel-write port at one pixel per clock, with transparency,
//   erase mode and horizontal mirroring.
//
//   Ports:
//     clk    : system clock, rising edge
//     resetn : asynchronous active-low reset
//     bus    : sprite_blitter_if.slave (request, ROM port, pixel port)
//
//   Pipeline (accept edge E0, pixel k):
//     cycle k+1 : address stage (rom_addr, col, row)
//     cycle k+2 : ROM stage (rom_q valid, col/row/valid carried along)
//     cycle k+3 : registered x, y, colour, plot
//
//   Configuration macro:
//     SPRITE_BLITTER_CLIP_EN : when defined, pixels outside SCREEN_W x
//     SCREEN_H are suppressed (plot=0, slot kept). When undefined,
//     coordinates simply wrap modulo 2^X_W / 2^Y_W.
// ---------------------------------------------------------------------------
module sprite_blitter #(
    parameter int SPRITE_W = 28,
    parameter int SPRITE_H = 20,
    parameter int ADDR_W   = 10,
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int COLOUR_W = 3,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = '0
) (
    input  logic             clk,
    input  logic             resetn,
    sprite_blitter_if.slave  bus
);

`ifdef SPRITE_BLITTER_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    // One extra bit so clipping compares the true, unwrapped coordinate.
    localparam int XS_W  = X_W + 1;
    localparam int YS_W  = Y_W + 1;

    localparam logic [ADDR_W-1:0] STRIDE        = ADDR_W'(SPRITE_W);
    localparam logic [ADDR_W-1:0] LAST_COL_ADDR = ADDR_W'(SPRITE_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    logic                r_drain;
    logic                r_busy;
    logic                r_done;

    // Request fields latched on accept.
    logic [X_W-1:0]      r_x_base;
    logic [Y_W-1:0]      r_y_base;
    logic                r_erase;
    logic                r_hflip;
    logic [COLOUR_W-1:0] r_bg;

    // Address stage.
    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;
    logic [ADDR_W-1:0]   r_row_base;
    logic [ADDR_W-1:0]   r_rom_addr;

    // ROM stage.
    logic                r_s1_valid;
    logic [COL_W-1:0]    r_s1_col;
    logic [ROW_W-1:0]    r_s1_row;

    // Output stage.
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [COLOUR_W-1:0] r_colour;
    logic                r_plot;

    logic                w_last_col;
    logic                w_last_row;
    logic [ADDR_W-1:0]   w_next_base;
    logic [ADDR_W-1:0]   w_first_col_addr;
    logic [XS_W-1:0]     w_x_sum;
    logic [YS_W-1:0]     w_y_sum;
    logic                w_clip_ok;
    logic                w_opaque;
    logic                w_plot_next;

    assign w_last_col       = (r_col == COL_W'(SPRITE_W - 1));
    assign w_last_row       = (r_row == ROW_W'(SPRITE_H - 1));
    // Row base is an accumulator stepped by SPRITE_W, so no multiplier.
    assign w_next_base      = r_row_base + STRIDE;
    // A mirrored row is walked right to left, starting at its last column.
    assign w_first_col_addr = r_hflip ? LAST_COL_ADDR : '0;

    assign w_x_sum     = {1'b0, r_x_base} + XS_W'(r_s1_col);
    assign w_y_sum     = {1'b0, r_y_base} + YS_W'(r_s1_row);
    assign w_clip_ok   = !CLIP_EN ||
                         ((w_x_sum < XS_W'(SCREEN_W)) && (w_y_sum < YS_W'(SCREEN_H)));
    assign w_opaque    = (bus.rom_q != TRANSPARENT);
    assign w_plot_next = r_s1_valid && (r_erase || w_opaque) && w_clip_ok;

    // Control FSM and address generation.
    // NOTE: sequential state uses non-blocking (<=) assignments so every
    // register samples the pre-edge values; blocking here would create
    // order-dependent simulation and mismatch the synthesised flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_drain    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_x_base   <= '0;
            r_y_base   <= '0;
            r_erase    <= 1'b0;
            r_hflip    <= 1'b0;
            r_bg       <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
            r_rom_addr <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_x_base   <= bus.x_pos_init;
                        r_y_base   <= bus.y_pos_init;
                        r_erase    <= bus.erase;
                        r_hflip    <= bus.hflip;
                        r_bg       <= bus.bg_colour;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_row_base <= '0;
                        // Uses the live hflip: r_hflip is only being loaded.
                        r_rom_addr <= bus.hflip ? LAST_COL_ADDR : '0;
                        r_drain    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_last_col) begin
                        if (w_last_row) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_col      <= '0;
                            r_row      <= r_row + 1'b1;
                            r_row_base <= w_next_base;
                            r_rom_addr <= w_next_base + w_first_col_addr;
                        end
                    end else begin
                        r_col      <= r_col + 1'b1;
                        r_rom_addr <= r_hflip ? (r_rom_addr - 1'b1) : (r_rom_addr + 1'b1);
                    end
                end
                S_DRAIN: begin
                    // Two cycles: the ROM stage and the output stage empty.
                    if (r_drain) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ROM-latency alignment and output registers.
    // NOTE: every pipeline register is reset, including the valid and the
    // data fields, so an aborted draw cannot leak a stale pixel or plot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1_valid <= 1'b0;
            r_s1_col   <= '0;
            r_s1_row   <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_colour   <= '0;
            r_plot     <= 1'b0;
        end else begin
            r_s1_valid <= (r_state == S_FETCH);
            r_s1_col   <= r_col;
            r_s1_row   <= r_row;
            r_plot     <= w_plot_next;
            // Coordinates and colour are held whenever nothing is plotted.
            if (w_plot_next) begin
                r_x      <= w_x_sum[X_W-1:0];
                r_y      <= w_y_sum[Y_W-1:0];
                r_colour <= r_erase ? r_bg : bus.rom_q;
            end
        end
    end

    assign bus.rom_addr = r_rom_addr;
    assign bus.x        = r_x;
    assign bus.y        = r_y;
    assign bus.colour   = r_colour;
    assign bus.plot     = r_plot;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_sprite_blitter.sv
// ---------------------------------------------------------------------------
// tb_sprite_blitter
//   Self-checking bench for sprite_blitter. A synchronous ROM model feeds the
//   DUT; a reference model computes, for each pixel index k, the expected
//   ROM address, plot decision, coordinates and colour straight from the
//   raster/mirror/transparency/clipping rules, and every cycle of a draw is
//   compared against it (busy, done, rom_addr, plot, x, y, colour).
// ---------------------------------------------------------------------------
module tb_sprite_blitter;

    localparam int W    = 28;
    localparam int H    = 20;
    localparam int N    = W * H;
    localparam int AW   = 10;
    localparam int X_W  = 9;
    localparam int Y_W  = 8;
    localparam int CW   = 3;
    localparam int SCR_W = 320;
    localparam int SCR_H = 240;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    sprite_blitter_if #(.ADDR_W(AW), .X_W(X_W), .Y_W(Y_W), .COLOUR_W(CW)) bus ();

    sprite_blitter #(
        .SPRITE_W(W), .SPRITE_H(H), .ADDR_W(AW), .X_W(X_W), .Y_W(Y_W),
        .COLOUR_W(CW), .SCREEN_W(SCR_W), .SCREEN_H(SCR_H), .TRANSPARENT(3'b000)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Sprite ROM: data one cycle after the address.
    logic [CW-1:0] rom [0:(1<<AW)-1];
    always @(posedge clk) bus.rom_q <= rom[bus.rom_addr];

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model results for the current draw.
    bit e_plot [N];
    int e_x    [N];
    int e_y    [N];
    int e_c    [N];
    int e_addr [N];
    int e_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic build_model(input int x0, input int y0, input bit er, input bit hf, input int bg);
        e_count = 0;
        for (int k = 0; k < N; k++) begin
            int col, row, idx, c, xs, ys;
            bit on;
            col = k % W;
            row = k / W;
            idx = row * W + (hf ? (W - 1 - col) : col);
            c   = er ? bg : int'(rom[idx]);
            xs  = x0 + col;
            ys  = y0 + row;
`ifdef SPRITE_BLITTER_CLIP_EN
            on  = (xs < SCR_W) && (ys < SCR_H);
`else
            on  = 1'b1;
`endif
            e_addr[k] = idx;
            e_plot[k] = (er || c != 0) && on;
            e_x[k]    = xs % (1 << X_W);
            e_y[k]    = ys % (1 << Y_W);
            e_c[k]    = c;
            if (e_plot[k]) e_count++;
        end
    endtask

    task automatic scramble_request();
        bus.x_pos_init = X_W'($urandom);
        bus.y_pos_init = Y_W'($urandom);
        bus.erase      = 1'($urandom);
        bus.hflip      = 1'($urandom);
        bus.bg_colour  = CW'($urandom);
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge of
    // cycle N+4, the last cycle before the earliest next accept.
    task automatic run_draw(input string name, input int x0, input int y0,
                            input bit er, input bit hf, input int bg, input bit hold);
        int seen;
        build_model(x0, y0, er, hf, bg);
        bus.x_pos_init = X_W'(x0);
        bus.y_pos_init = Y_W'(y0);
        bus.erase      = er;
        bus.hflip      = hf;
        bus.bg_colour  = CW'(bg);
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
        scramble_request();
        seen = 0;
        for (int c = 1; c <= N + 4; c++) begin
            int  k;
            bit  ep;
            @(negedge clk);
            check({name, " busy"}, 32'(bus.busy), 32'(c <= N + 2));
            check({name, " done"}, 32'(bus.done), 32'(c == N + 3));
            if (c <= N) check({name, " rom_addr"}, 32'(bus.rom_addr), e_addr[c-1]);
            k  = c - 3;
            ep = (k >= 0 && k < N) ? e_plot[k] : 1'b0;
            check({name, " plot"}, 32'(bus.plot), 32'(ep));
            if (bus.plot && ep) begin
                check({name, " x"},      32'(bus.x),      e_x[k]);
                check({name, " y"},      32'(bus.y),      e_y[k]);
                check({name, " colour"}, 32'(bus.colour), e_c[k]);
            end
            if (bus.plot) seen++;
        end
        check({name, " plot_count"}, seen, e_count);
    endtask

    task automatic fill_rom_random();
        for (int i = 0; i < (1 << AW); i++) rom[i] = CW'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn         = 1'b0;
        bus.start      = 1'b0;
        bus.x_pos_init = '0;
        bus.y_pos_init = '0;
        bus.erase      = 1'b0;
        bus.hflip      = 1'b0;
        bus.bg_colour  = '0;
        for (int i = 0; i < (1 << AW); i++) rom[i] = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst plot",     32'(bus.plot),     0);
        check("rst busy",     32'(bus.busy),     0);
        check("rst done",     32'(bus.done),     0);
        check("rst rom_addr", 32'(bus.rom_addr), 0);
        check("rst x",        32'(bus.x),        0);
        check("rst y",        32'(bus.y),        0);
        check("rst colour",   32'(bus.colour),   0);
        resetn = 1'b1;
        @(negedge clk);

        // Basic draw.
        for (int i = 0; i < (1 << AW); i++) rom[i] = CW'(i % 7 + 1);
        run_draw("basic", 10, 20, 1'b0, 1'b0, int'($urandom_range(7)), 1'b0);

        // Transparency: a single opaque pixel, then erase with colour 0.
        for (int i = 0; i < (1 << AW); i++) rom[i] = '0;
        rom[29] = 3'b101;
        run_draw("transp", int'($urandom_range(200)), int'($urandom_range(150)),
                 1'b0, 1'b0, int'($urandom_range(7)), 1'b0);
        run_draw("erase0", int'($urandom_range(200)), int'($urandom_range(150)),
                 1'b1, 1'b0, 0, 1'b0);

        // Mirror.
        fill_rom_random();
        for (int c = 0; c < W; c++) rom[c] = CW'(c);
        run_draw("mirror", 0, 0, 1'b0, 1'b1, 0, 1'b0);

        // Screen edge: clipped or wrapped depending on the build.
        for (int i = 0; i < (1 << AW); i++) rom[i] = CW'(i % 7 + 1);
        run_draw("edge", 310, 230, 1'b0, 1'b0, 0, 1'b0);

        // start held high through a draw: next accept exactly after IDLE.
        fill_rom_random();
        run_draw("hold", int'($urandom_range(511)), int'($urandom_range(255)),
                 1'($urandom), 1'($urandom), int'($urandom_range(7)), 1'b1);
        run_draw("after_hold", int'($urandom_range(511)), int'($urandom_range(255)),
                 1'($urandom), 1'($urandom), int'($urandom_range(7)), 1'b0);

        // Reset in cycle 200 of a draw.
        bus.x_pos_init = X_W'($urandom);
        bus.y_pos_init = Y_W'($urandom);
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (200) @(negedge clk);
        check("pre-abort busy", 32'(bus.busy), 1);
        resetn = 1'b0;
        #1;
        check("abort plot",     32'(bus.plot),     0);
        check("abort busy",     32'(bus.busy),     0);
        check("abort done",     32'(bus.done),     0);
        check("abort rom_addr", 32'(bus.rom_addr), 0);
        check("abort x",        32'(bus.x),        0);
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < N + 10; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.plot) begin
                check("post-abort quiet", {29'd0, bus.done, bus.busy, bus.plot}, 0);
            end
        end
        check("post-abort done", 32'(bus.done), 0);
        run_draw("redraw", int'($urandom_range(290)), int'($urandom_range(220)),
                 1'b0, 1'b0, 0, 1'b0);

        // Random draws.
        for (int r = 0; r < 3; r++) begin
            fill_rom_random();
            run_draw("random", int'($urandom_range(511)), int'($urandom_range(255)),
                     1'($urandom), 1'($urandom), int'($urandom_range(7)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
